sram_like_arbiter: RTL and testbench

- Shares one sram-like slave port between two sram-like masters: the instruction-fetch port (inst_*) and the data port (data_*).
- Sits between the CPU core's inst_sram/data_sram interfaces and the downstream bridge or cache.
- Tracks the owner of every accepted request in an in-order ownership FIFO, and routes each m_data_ok/m_rdata back to the correct master.
- Holds a grant stable until the address handshake completes, as the sram-like protocol requires.

---
 rtl/sram_like_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between the instruction
// fetch master (inst_*) and the data master (data_*).
// Every accepted request records its owner in an in-order FIFO, and each
// m_data_ok/m_rdata response is steered back to the master at the FIFO head.
// A grant stays locked while its address handshake is stalled.
// Optional feature: define ARB_RR_EN to get round-robin arbitration between
// simultaneous unlocked requests. Without it, data has fixed priority over inst.
module sram_like_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [3:0]       m_wstrb,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,

    output logic [CNT_W-1:0] outst_cnt,
    output logic             err_spurious
);

    localparam int   PTR_W      = (OUTST_DEPTH > 2) ? $clog2(OUTST_DEPTH) : 1;
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Ownership FIFO storage and pointers
    logic [OUTST_DEPTH-1:0] owner_fifo_q, owner_fifo_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       outst_cnt_q, outst_cnt_d;

    // Grant lock held across a stalled address handshake
    logic                   grant_lock_v_q, grant_lock_v_d;
    logic                   grant_lock_q, grant_lock_d;

    // Sticky error for responses nobody asked for
    logic                   err_spurious_q, err_spurious_d;

`ifdef ARB_RR_EN
    // Owner of the most recent address handshake, used for fairness
    logic                   last_grant_q, last_grant_d;
`endif

    logic                   full;
    logic                   fifo_empty;
    logic                   any_req;
    logic                   grant;
    logic                   push;
    logic                   pop;
    logic                   spurious;
    logic                   head_owner;

    assign full       = (outst_cnt_q == CNT_W'(OUTST_DEPTH));
    assign fifo_empty = (outst_cnt_q == '0);
    assign any_req    = inst_req | data_req;
    assign head_owner = owner_fifo_q[rd_ptr_q];

    // Pick the master that owns the slave port this cycle
    always_comb begin
        grant = OWNER_INST;
        if (grant_lock_v_q) begin
            grant = grant_lock_q;
        end
`ifdef ARB_RR_EN
        else if (inst_req && data_req) begin
            grant = ~last_grant_q;
        end
`endif
        else begin
            grant = data_req ? OWNER_DATA : OWNER_INST;
        end
    end

    // Request path: forward the granted master's fields, zero when idle or in reset
    always_comb begin
        m_req   = resetn & any_req & ~full;
        m_wr    = 1'b0;
        m_size  = 2'b00;
        m_wstrb = 4'b0000;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        if (m_req) begin
            if (grant == OWNER_DATA) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_wstrb = data_wstrb;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_wstrb = inst_wstrb;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    // Handshake and response steering back to the two masters
    always_comb begin
        push         = m_req & m_addr_ok;
        pop          = resetn & m_data_ok & ~fifo_empty;
        spurious     = resetn & m_data_ok & fifo_empty;
        inst_addr_ok = push & (grant == OWNER_INST);
        data_addr_ok = push & (grant == OWNER_DATA);
        inst_data_ok = pop & (head_owner == OWNER_INST);
        data_data_ok = pop & (head_owner == OWNER_DATA);
        inst_rdata   = resetn ? m_rdata : 32'h0;
        data_rdata   = resetn ? m_rdata : 32'h0;
    end

    // Next-state for the ownership FIFO and outstanding count
    always_comb begin
        owner_fifo_d = owner_fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        outst_cnt_d  = outst_cnt_q;
        if (push) begin
            owner_fifo_d[wr_ptr_q] = grant;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   outst_cnt_d = outst_cnt_q + CNT_W'(1);
            2'b01:   outst_cnt_d = outst_cnt_q - CNT_W'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase
    end

    // Next-state for grant lock, error flag and fairness history
    always_comb begin
        grant_lock_v_d = m_req & ~m_addr_ok;
        grant_lock_d   = (m_req & ~m_addr_ok) ? grant : grant_lock_q;
        err_spurious_d = err_spurious_q | spurious;
`ifdef ARB_RR_EN
        last_grant_d   = push ? grant : last_grant_q;
`endif
    end

    // State registers, cleared asynchronously by resetn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_fifo_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            outst_cnt_q    <= '0;
            grant_lock_v_q <= 1'b0;
            grant_lock_q   <= OWNER_INST;
            err_spurious_q <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q   <= OWNER_INST;
`endif
        end else begin
            owner_fifo_q   <= owner_fifo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            outst_cnt_q    <= outst_cnt_d;
            grant_lock_v_q <= grant_lock_v_d;
            grant_lock_q   <= grant_lock_d;
            err_spurious_q <= err_spurious_d;
`ifdef ARB_RR_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    assign outst_cnt    = outst_cnt_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios with literal expectations followed
// by randomized master/slave traffic, all checked every cycle against a
// queue-based model of the arbiter kept in this bench.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic [CNT_W-1:0] outst_cnt;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    // Model state: owners of accepted requests in order, plus lock and flags
    bit owner_q[$];
    bit lock_v, lock_owner, last_owner, err_flag;
    bit inst_hs, data_hs;

    sram_like_arbiter #(.OUTST_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outst_cnt(outst_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, compares every output, then advances
    always @(negedge clk) begin : model_compare
        bit          exp_full, exp_grant, exp_mreq, exp_push, exp_pop, exp_head;
        logic [6:0]  exp_ctrl;
        logic [63:0] exp_aw;
        if (!resetn) begin
            checkOutput("reset_ctrl",
                {m_req, m_wr, m_size, m_wstrb, inst_addr_ok, inst_data_ok,
                 data_addr_ok, data_data_ok, outst_cnt, err_spurious}, 64'd0);
            checkOutput("reset_addr_wdata", {m_addr, m_wdata}, 64'd0);
            checkOutput("reset_rdata", {inst_rdata, data_rdata}, 64'd0);
            owner_q.delete();
            lock_v = 0; lock_owner = 0; last_owner = 0; err_flag = 0;
            inst_hs = 0; data_hs = 0;
        end else begin
            exp_full = (owner_q.size() == DEPTH);
            if (lock_v) exp_grant = lock_owner;
`ifdef ARB_RR_EN
            else if (inst_req && data_req) exp_grant = !last_owner;
`endif
            else exp_grant = data_req;
            exp_mreq = (inst_req || data_req) && !exp_full;
            exp_push = exp_mreq && m_addr_ok;
            exp_pop  = m_data_ok && (owner_q.size() > 0);
            exp_head = exp_pop ? owner_q[0] : 1'b0;
            exp_ctrl = '0;
            exp_aw   = '0;
            if (exp_mreq) begin
                exp_ctrl = exp_grant ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb};
                exp_aw   = exp_grant ? {data_addr, data_wdata} : {inst_addr, inst_wdata};
            end
            checkOutput("m_req", m_req, exp_mreq);
            checkOutput("m_ctrl", {m_wr, m_size, m_wstrb}, exp_ctrl);
            checkOutput("m_addr_wdata", {m_addr, m_wdata}, exp_aw);
            checkOutput("addr_ok", {inst_addr_ok, data_addr_ok},
                        {exp_push && !exp_grant, exp_push && exp_grant});
            checkOutput("data_ok", {inst_data_ok, data_data_ok},
                        {exp_pop && !exp_head, exp_pop && exp_head});
            checkOutput("rdata", {inst_rdata, data_rdata}, {m_rdata, m_rdata});
            checkOutput("outst_cnt", outst_cnt, owner_q.size());
            checkOutput("err_spurious", err_spurious, err_flag);
            inst_hs = exp_push && !exp_grant;
            data_hs = exp_push && exp_grant;
            if (m_data_ok && owner_q.size() == 0) err_flag = 1;
            if (exp_pop) void'(owner_q.pop_front());
            if (exp_push) begin
                owner_q.push_back(exp_grant);
                last_owner = exp_grant;
            end
            lock_v = exp_mreq && !m_addr_ok;
            if (lock_v) lock_owner = exp_grant;
        end
    end

    task automatic idleInputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'h0;
    endtask

    // Drives one cycle of inputs just after the clock edge, then waits mid-cycle
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic aok, input logic dok,
                                 input logic [31:0] rdata);
        @(posedge clk); #1;
        inst_req = ireq; inst_addr = iaddr; inst_wr = 0; inst_wstrb = 4'h0;
        inst_wdata = 32'h0;
        data_req = dreq; data_addr = daddr; data_wr = 1; data_wstrb = 4'hf;
        data_wdata = daddr ^ 32'h5a5a_0000;
        m_addr_ok = aok; m_data_ok = dok; m_rdata = rdata;
        @(negedge clk);
    endtask

    initial begin : stimulus
        bit ipend, dpend;
        idleInputs();
        resetn = 0;
        inst_req = 1; data_req = 1; m_data_ok = 1; m_rdata = 32'hdead_beef;
        @(negedge clk);
        checkOutput("rst_m_req", m_req, 1'b0);
        checkOutput("rst_cnt", outst_cnt, 0);
        checkOutput("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        @(posedge clk); #1;
        idleInputs();
        resetn = 1;

        // Single inst read
        applyStimulus(1, 32'h0000_0100, 0, 0, 1, 0, 0);
        checkOutput("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        checkOutput("t1_m_addr", m_addr, 32'h0000_0100);
        checkOutput("t1_cnt0", outst_cnt, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h3c00_0001);
        checkOutput("t1_inst_data_ok", inst_data_ok, 1'b1);
        checkOutput("t1_inst_rdata", inst_rdata, 32'h3c00_0001);
        checkOutput("t1_cnt1", outst_cnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_cnt_back0", outst_cnt, 0);

        // Simultaneous requests: data first, responses in order
        applyStimulus(1, 32'h1000, 1, 32'h2000, 1, 0, 0);
        checkOutput("t2_m_addr_data", m_addr, 32'h2000);
        checkOutput("t2_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        applyStimulus(1, 32'h1000, 0, 0, 1, 0, 0);
        checkOutput("t2_m_addr_inst", m_addr, 32'h1000);
        checkOutput("t2_inst_addr_ok", inst_addr_ok, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hd0);
        checkOutput("t2_first_resp", {inst_data_ok, data_data_ok}, 2'b01);
        checkOutput("t2_cnt2", outst_cnt, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'ha0);
        checkOutput("t2_second_resp", {inst_data_ok, data_data_ok}, 2'b10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Stalled inst handshake keeps its grant against a new data request
        applyStimulus(1, 32'h1000, 0, 0, 0, 0, 0);
        checkOutput("t3_c1_m_addr", m_addr, 32'h1000);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 0, 0, 0);
        checkOutput("t3_c2_m_addr", m_addr, 32'h1000);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 0, 0, 0);
        checkOutput("t3_c3_m_addr", m_addr, 32'h1000);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 1, 0, 0);
        checkOutput("t3_c4_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        applyStimulus(0, 0, 1, 32'h2000, 1, 0, 0);
        checkOutput("t3_c5_m_addr", m_addr, 32'h2000);
        checkOutput("t3_c5_data_addr_ok", data_addr_ok, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_cnt0", outst_cnt, 0);

        // Fill the FIFO, then free one slot
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 32'h40 + i, 1, 0, 0);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 1, 0, 0);
        checkOutput("t4_full_cnt", outst_cnt, 4);
        checkOutput("t4_full_m_req", m_req, 1'b0);
        checkOutput("t4_full_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 1, 1, 32'h7);
        checkOutput("t4_pop_m_req", m_req, 1'b0);
        checkOutput("t4_pop_data_ok", data_data_ok, 1'b1);
        applyStimulus(1, 32'h1000, 1, 32'h2000, 1, 0, 0);
        checkOutput("t4_reassert_m_req", m_req, 1'b1);
        checkOutput("t4_cnt3", outst_cnt, 3);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 1, 32'h8 + i);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_drained", outst_cnt, 0);

        // Push and pop together at count 2
        applyStimulus(1, 32'h300, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 32'h400, 1, 0, 0);
        applyStimulus(1, 32'h304, 0, 0, 1, 1, 32'h11);
        checkOutput("t5_cnt2", outst_cnt, 2);
        checkOutput("t5_pulse", {inst_data_ok, data_data_ok, inst_addr_ok}, 3'b101);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h22);
        checkOutput("t5_cnt_still2", outst_cnt, 2);
        checkOutput("t5_data_resp", {inst_data_ok, data_data_ok}, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h33);
        checkOutput("t5_inst_resp", {inst_data_ok, data_data_ok}, 2'b10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset drops an outstanding request; its late response is spurious
        applyStimulus(1, 32'h500, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        idleInputs();
        resetn = 0;
        @(negedge clk);
        checkOutput("t6_reset_cnt", outst_cnt, 0);
        @(posedge clk); #1;
        resetn = 1;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h99);
        checkOutput("t6_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_err_set", err_spurious, 1'b1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_err_sticky", err_spurious, 1'b1);
        @(posedge clk); #1;
        resetn = 0;
        @(negedge clk);
        checkOutput("t6_err_cleared", err_spurious, 1'b0);
        @(posedge clk); #1;
        resetn = 1;

        // Random traffic; masters hold a request until it is accepted
        ipend = 0; dpend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == 1500) begin
                resetn = 0; ipend = 0; dpend = 0;
            end else if (c == 1504) begin
                resetn = 1;
            end
            if (ipend && inst_hs) ipend = 0;
            if (dpend && data_hs) dpend = 0;
            if (!ipend && $urandom_range(0, 1) == 1) begin
                ipend = 1;
                inst_wr = $urandom_range(0, 1) == 1; inst_size = 2'($urandom);
                inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!dpend && $urandom_range(0, 2) != 0) begin
                dpend = 1;
                data_wr = $urandom_range(0, 1) == 1; data_size = 2'($urandom);
                data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req  = ipend;
            data_req  = dpend;
            m_addr_ok = $urandom_range(0, 9) < 6;
            if (owner_q.size() > 0) m_data_ok = $urandom_range(0, 2) == 0;
            else m_data_ok = $urandom_range(0, 39) == 0;
            m_rdata = $urandom;
        end
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
